// File: rtl/im_c2d_pkg.sv
// rtl/im_c2d_pkg.sv - shared widths, FSM state type and helpers for the IM-to-DRAM dump engine
package im_c2d_pkg;

    localparam int DDR_AXI_ADDR_WIDTH  = 32;
    localparam int DDR_LEN_WIDTH       = 20;
    localparam int DDR_AXIS_DATA_WIDTH = 512;
    localparam int INS_RAM_DEPTH       = 8192;
    localparam int INS_RAM_DATA_WIDTH  = 512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DESC   = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/im_c2d_fifo.sv
// rtl/im_c2d_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module im_c2d_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + (do_wr ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (do_rd ? AW'(1) : AW'(0));
        count_d  = count_q + (do_wr ? (AW+1)'(1) : (AW+1)'(0))
                           - (do_rd ? (AW+1)'(1) : (AW+1)'(0));
    end

    // Storage is not reset; the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/im_c2d.sv
// rtl/im_c2d.sv - streams instruction RAM contents to the DMA write channel; IM_C2D_OUT_REG_EN adds an AXIS output register slice
module im_c2d
    import im_c2d_pkg::*;
#(
    parameter int DATA_WIDTH     = DDR_AXIS_DATA_WIDTH,
    parameter int AXI_ADDR_WIDTH = DDR_AXI_ADDR_WIDTH,
    parameter int LEN_WIDTH      = DDR_LEN_WIDTH,
    parameter int RAM_AW         = $clog2(INS_RAM_DEPTH),
    parameter int RD_LATENCY     = 2,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_pulse,
    input  logic [31:0]               d_addr,
    input  logic [31:0]               n_bytes,
    output logic                      busy,
    output logic                      done_pulse,
    output logic [AXI_ADDR_WIDTH-1:0] dma_wr_desc_addr,
    output logic [LEN_WIDTH-1:0]      dma_wr_desc_len,
    output logic                      dma_wr_desc_valid,
    input  logic                      dma_wr_desc_ready,
    input  logic                      dma_wr_desc_status_valid,
    output logic [DATA_WIDTH-1:0]     dma_wr_write_data_tdata,
    output logic                      dma_wr_write_data_tvalid,
    input  logic                      dma_wr_write_data_tready,
    output logic                      dma_wr_write_data_tlast,
    output logic                      rd_en,
    output logic [RAM_AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0]     dout
);
    localparam int BPB_LOG = $clog2(DATA_WIDTH / 8);
    localparam int BW      = LEN_WIDTH + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [BW-1:0]             n_beats_q, n_beats_d;
    logic [BW-1:0]             issued_q, issued_d;
    logic [BW-1:0]             pushed_q, pushed_d;
    logic                      rd_en_q, rd_en_d;
    logic [RAM_AW-1:0]         rd_addr_q, rd_addr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      desc_valid_q, desc_valid_d;
    logic [RD_LATENCY-1:0]     sr_q, sr_d;

    logic [LEN_WIDTH-1:0]      start_len;
    logic [BW-1:0]             start_beats;
    logic [31:0]               outstanding;
    logic                      issue_ok;

    logic                      fifo_push, fifo_pop, fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [DATA_WIDTH:0]       fifo_wr_data, fifo_rd_data;

    logic                      axis_valid, axis_last, axis_fire;
    logic [DATA_WIDTH-1:0]     axis_data;
    logic                      unused_bits;

    assign unused_bits  = ^n_bytes[31:LEN_WIDTH];

    assign start_len    = n_bytes[LEN_WIDTH-1:0];
    assign start_beats  = (BW'(start_len) + BW'((DATA_WIDTH / 8) - 1)) >> BPB_LOG;

    // rd_en_q is the read-issue strobe; sr_q tracks it down to the cycle dout is valid.
    assign fifo_push    = sr_q[RD_LATENCY-1];
    assign fifo_wr_data = {(pushed_q == n_beats_q - BW'(1)), dout};

    // Credits: every read issued but not yet popped must fit in the FIFO.
    assign outstanding  = 32'(fifo_count) + 32'(rd_en_q) + popcount32(32'(sr_q))
                        - 32'(fifo_pop);
    assign issue_ok     = ((state_q == ST_STREAM) ||
                           (state_q == ST_DESC && dma_wr_desc_ready)) &&
                          (outstanding < 32'(FIFO_DEPTH)) &&
                          (issued_q < n_beats_q);

    im_c2d_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (),
        .count   (fifo_count)
    );

`ifdef IM_C2D_OUT_REG_EN
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    assign fifo_pop = !fifo_empty && (!out_valid_q || dma_wr_write_data_tready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (fifo_pop) begin
            out_valid_d = 1'b1;
            out_last_d  = fifo_rd_data[DATA_WIDTH];
            out_data_d  = fifo_rd_data[DATA_WIDTH-1:0];
        end else if (dma_wr_write_data_tready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign axis_valid = out_valid_q;
    assign axis_last  = out_last_q;
    assign axis_data  = out_data_q;
`else
    assign fifo_pop   = !fifo_empty && dma_wr_write_data_tready;
    assign axis_valid = !fifo_empty;
    assign axis_last  = !fifo_empty && fifo_rd_data[DATA_WIDTH];
    assign axis_data  = fifo_empty ? '0 : fifo_rd_data[DATA_WIDTH-1:0];
`endif

    assign axis_fire  = axis_valid && dma_wr_write_data_tready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        n_beats_d = n_beats_q;
        rd_en_d   = issue_ok;
        issued_d  = issued_q + BW'(issue_ok);
        rd_addr_d = issue_ok ? RAM_AW'(issued_q) : rd_addr_q;
        pushed_d  = pushed_q + BW'(fifo_push);
        sr_d      = (sr_q << 1) | RD_LATENCY'(rd_en_q);
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    addr_d    = d_addr[AXI_ADDR_WIDTH-1:0];
                    len_d     = start_len;
                    n_beats_d = start_beats;
                    issued_d  = '0;
                    pushed_d  = '0;
                    if (start_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DESC;
                    end
                end
            end
            ST_DESC: begin
                if (dma_wr_desc_ready) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (axis_fire && axis_last) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dma_wr_desc_status_valid) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d       = (state_d != ST_IDLE);
        desc_valid_d = (state_d == ST_DESC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            n_beats_q    <= '0;
            issued_q     <= '0;
            pushed_q     <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            sr_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            desc_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            n_beats_q    <= n_beats_d;
            issued_q     <= issued_d;
            pushed_q     <= pushed_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            sr_q         <= sr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            desc_valid_q <= desc_valid_d;
        end
    end

    assign busy                     = busy_q;
    assign done_pulse               = done_q;
    assign dma_wr_desc_addr         = addr_q;
    assign dma_wr_desc_len          = len_q;
    assign dma_wr_desc_valid        = desc_valid_q;
    assign rd_en                    = rd_en_q;
    assign rd_addr                  = rd_addr_q;
    assign dma_wr_write_data_tdata  = axis_data;
    assign dma_wr_write_data_tvalid = axis_valid;
    assign dma_wr_write_data_tlast  = axis_last;

endmodule
